// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the iterative right shifter (shiftr_seq).
// Rotate support in the top level is enabled by defining SHIFTR_ROTATE_EN.
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

    localparam int SHIFTR_M_DEFAULT     = 4;
    localparam int SHIFTR_CNT_W_DEFAULT = $clog2(SHIFTR_M_DEFAULT) + 1;

    // Count register width: must hold shift amounts 0..m inclusive.
    function automatic int cnt_width(input int m);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/shiftr_seq_shr1.sv
// One-bit right step used by the shiftr_seq datapath: shifts din right by one,
// inserting fill at the MSB and reporting the bit that leaves the LSB.
module shr1 #(
    parameter int M = 4
) (
    input  logic [M-1:0] din,
    input  logic         fill,
    output logic [M-1:0] dout,
    output logic         out_bit
);

    assign dout    = {fill, din[M-1:1]};
    assign out_bit = din[0];

endmodule

// File: rtl/shiftr_seq.sv
// Iterative right shifter with ALU flags: one bit per clock, done pulse on completion.
// Define SHIFTR_ROTATE_EN to build the rotate-right mode selected by rot.
module shiftr_seq
    import shift_pkg::*;
#(
    parameter int M = SHIFTR_M_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    input  logic         arith,
    input  logic         rot,
    output logic [M-1:0] R,
    output logic         C,
    output logic         N,
    output logic         V,
    output logic         Z,
    output logic         busy,
    output logic         done
);

    localparam int                 CNT_W = cnt_width(M);
    localparam int                 LOG_M = $clog2(M);
    localparam logic [M:0]         M_VAL = (M + 1)'(M);
    localparam logic [CNT_W-1:0]   M_CNT = CNT_W'(M);

    shift_state_t     r_state;
    logic [M-1:0]     r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cint;
    logic             r_arith;
    logic [M-1:0]     r_res;
    logic             r_c;
    logic             r_n;
    logic             r_v;
    logic             r_z;
    logic             r_busy;
    logic             r_done;

    logic [CNT_W-1:0] w_k;
    logic             w_fill;
    logic [M-1:0]     w_dout;
    logic             w_out_bit;

`ifdef SHIFTR_ROTATE_EN
    logic             r_rot;
`else
    logic             w_unused_rot;
    assign w_unused_rot = rot;
`endif

    // Step count latched at start: saturate shifts at M, rotate uses B modulo M.
    always_comb begin
        w_k = M_CNT;
`ifdef SHIFTR_ROTATE_EN
        if (rot) begin
            w_k = CNT_W'(B[LOG_M-1:0]);
        end else if ({1'b0, B} < M_VAL) begin
            w_k = B[CNT_W-1:0];
        end else begin
            w_k = M_CNT;
        end
`else
        if ({1'b0, B} < M_VAL) begin
            w_k = B[CNT_W-1:0];
        end else begin
            w_k = M_CNT;
        end
`endif
    end

    // Bit entering the MSB on each step: zero, replicated sign, or wrapped LSB.
    always_comb begin
        w_fill = 1'b0;
`ifdef SHIFTR_ROTATE_EN
        if (r_rot) begin
            w_fill = r_sh[0];
        end else if (r_arith) begin
            w_fill = r_sh[M-1];
        end else begin
            w_fill = 1'b0;
        end
`else
        if (r_arith) begin
            w_fill = r_sh[M-1];
        end else begin
            w_fill = 1'b0;
        end
`endif
    end

    shr1 #(.M(M)) u_shr1 (
        .din     (r_sh),
        .fill    (w_fill),
        .dout    (w_dout),
        .out_bit (w_out_bit)
    );

    // Control FSM, shift datapath and registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh    <= {M{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_cint  <= 1'b0;
            r_arith <= 1'b0;
`ifdef SHIFTR_ROTATE_EN
            r_rot   <= 1'b0;
`endif
            r_res   <= {M{1'b0}};
            r_c     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_v <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sh    <= A;
                        r_cnt   <= w_k;
                        r_cint  <= 1'b0;
                        r_arith <= arith;
`ifdef SHIFTR_ROTATE_EN
                        r_rot   <= rot;
`endif
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_sh   <= w_dout;
                        r_cint <= w_out_bit;
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end else begin
                        r_res   <= r_sh;
                        r_c     <= r_cint;
                        r_n     <= r_sh[M-1];
                        r_z     <= (r_sh == {M{1'b0}});
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // start is ignored here; the controller re-asserts it once idle.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign R    = r_res;
    assign C    = r_c;
    assign N    = r_n;
    assign V    = r_v;
    assign Z    = r_z;
    assign busy = r_busy;
    assign done = r_done;

endmodule
